// File: rtl/ring_mem_responder.sv
// Memory-side responder at ring position 0. It consumes Address and
// WriteData slots from the cache stations, queues DRAM line commands,
// grants exclusivity to SHARED holders, and returns read lines on RDreturn/RDdest.
module ring_mem_responder #(
   parameter int unsigned NCORES             = 4,
   parameter int unsigned FIFO_DEPTH         = 4,
   parameter logic [3:0]  SlotAddress        = 4'd1,
   parameter logic [3:0]  SlotWriteData      = 4'd2,
   parameter logic [3:0]  SlotGrantExclusive = 4'd3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] RingIn,
   input  logic [3:0]  SlotTypeIn,
   input  logic [3:0]  SourceIn,
   output logic [31:0] mrRingOut,
   output logic [3:0]  mrSlotTypeOut,
   output logic [3:0]  mrSourceOut,
   output logic        mrDriveRing,
   output logic [31:0] RDreturn,
   output logic [3:0]  RDdest,
   output logic        memCmdValid,
   input  logic        memCmdReady,
   output logic        memCmdWrite,
   output logic [27:0] memCmdAddr,
   output logic [31:0] memWData,
   output logic        memWValid,
   input  logic [31:0] memRData,
   input  logic        memRValid,
   output logic        protocolErr
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StIssue  = 2'd1;
   localparam logic [1:0] StWBurst = 2'd2;

   // Command entry: [32] write, [31:28] read dest (write: [28] = buffer index), [27:0] line address
   logic [32:0]     cmdFifo [FIFO_DEPTH];
   logic [PtrW-1:0] fifoWrPtr, fifoRdPtr;
   logic [CntW-1:0] fifoCount;
   logic            fifoPush, fifoPop;
   logic [32:0]     fifoPushData;
   logic [32:0]     cmdHead;

   logic [31:0] lineBuf [2][8];
   logic [1:0]  bufFull;
   logic        fillSel;
   logic [3:0]  wdCnt;
   logic        wdWrite, waDone, bufFree, errSet, eligible;

   logic [1:0] state, stateNext;
   logic [2:0] wBeat;

   logic [3:0] destQ [4];
   logic [1:0] dqWrPtr, dqRdPtr;
   logic [2:0] dqCount;
   logic       dqPush, dqPop, beatOk;
   logic [2:0] rBeat;

   assign cmdHead = cmdFifo[fifoRdPtr];
   assign beatOk  = memRValid && (dqCount != 3'd0);
   assign dqPop   = beatOk && (rBeat == 3'd7);

   // Ring slot decode: decide push/drive/error purely from this cycle's slot
   always_comb begin
      mrRingOut     = '0;
      mrSlotTypeOut = '0;
      mrSourceOut   = '0;
      mrDriveRing   = 1'b0;
      fifoPush      = 1'b0;
      fifoPushData  = '0;
      wdWrite       = 1'b0;
      waDone        = 1'b0;
      errSet        = 1'b0;
      eligible      = (SourceIn != 4'd0) && (32'(SourceIn) <= NCORES) && !RingIn[31];
      if (!reset && eligible) begin
         if (SlotTypeIn == SlotWriteData) begin
            if ((wdCnt < 4'd8) && !bufFull[fillSel]) wdWrite = 1'b1;
            else errSet = 1'b1;
         end else if (SlotTypeIn == SlotAddress) begin
            if (!RingIn[28]) begin
               if (wdCnt != 4'd8) begin
                  errSet = 1'b1;
               end else begin
                  // Write-backs never bounce: at most two buffers' worth can be queued,
                  // and reads leave that headroom in the FIFO.
                  waDone       = 1'b1;
                  fifoPush     = 1'b1;
                  fifoPushData = {1'b1, 3'b000, fillSel, RingIn[27:0]};
                  mrDriveRing  = 1'b1;
               end
            end else if (RingIn[30:29] == 2'b11) begin
               mrDriveRing   = 1'b1;
               mrSlotTypeOut = SlotGrantExclusive;
               mrSourceOut   = SourceIn;
               mrRingOut     = RingIn;
            end else if (32'(fifoCount) < FIFO_DEPTH - 32'd2) begin
               fifoPush     = 1'b1;
               fifoPushData = {1'b0, SourceIn, RingIn[27:0]};
               mrDriveRing  = 1'b1;
            end else begin
               mrDriveRing   = 1'b1;
               mrSlotTypeOut = SlotTypeIn;
               mrSourceOut   = SourceIn;
               mrRingOut     = RingIn | 32'h8000_0000;
            end
         end
      end
   end

   // Command issue FSM next state and DRAM-side outputs
   always_comb begin
      stateNext   = state;
      fifoPop     = 1'b0;
      dqPush      = 1'b0;
      bufFree     = 1'b0;
      memCmdValid = (state == StIssue) && (cmdHead[32] || (dqCount != 3'd4));
      memCmdWrite = memCmdValid && cmdHead[32];
      memCmdAddr  = memCmdValid ? cmdHead[27:0] : 28'd0;
      memWValid   = (state == StWBurst);
      memWData    = memWValid ? lineBuf[cmdHead[28]][wBeat] : 32'd0;
      case (state)
         StIdle: begin
            if (fifoCount != '0) stateNext = StIssue;
         end
         StIssue: begin
            if (memCmdValid && memCmdReady) begin
               if (cmdHead[32]) begin
                  stateNext = StWBurst;
               end else begin
                  dqPush    = 1'b1;
                  fifoPop   = 1'b1;
                  stateNext = StIdle;
               end
            end
         end
         StWBurst: begin
            if (wBeat == 3'd7) begin
               fifoPop   = 1'b1;
               bufFree   = 1'b1;
               stateNext = StIdle;
            end
         end
         default: stateNext = StIdle;
      endcase
   end

   // Command FIFO storage; push and pop in one cycle leave occupancy unchanged
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) cmdFifo[i] <= '0;
         fifoWrPtr <= '0;
         fifoRdPtr <= '0;
         fifoCount <= '0;
      end else begin
         if (fifoPush) begin
            cmdFifo[fifoWrPtr] <= fifoPushData;
            fifoWrPtr <= (fifoWrPtr == PtrW'(FIFO_DEPTH - 1)) ? '0 : fifoWrPtr + PtrW'(1);
         end
         if (fifoPop) begin
            fifoRdPtr <= (fifoRdPtr == PtrW'(FIFO_DEPTH - 1)) ? '0 : fifoRdPtr + PtrW'(1);
         end
         case ({fifoPush, fifoPop})
            2'b10:   fifoCount <= fifoCount + CntW'(1);
            2'b01:   fifoCount <= fifoCount - CntW'(1);
            default: fifoCount <= fifoCount;
         endcase
      end
   end

   // Ping-pong line buffers: fill one while the other may be draining
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 2; b++)
            for (int w = 0; w < 8; w++) lineBuf[b][w] <= '0;
         bufFull <= '0;
         fillSel <= 1'b0;
         wdCnt   <= '0;
      end else begin
         if (wdWrite) begin
            lineBuf[fillSel][wdCnt[2:0]] <= RingIn;
            wdCnt <= wdCnt + 4'd1;
         end
         if (waDone) begin
            bufFull[fillSel] <= 1'b1;
            fillSel          <= ~fillSel;
            wdCnt            <= '0;
         end
         if (bufFree) bufFull[cmdHead[28]] <= 1'b0;
      end
   end

   // FSM state and write-burst beat counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= StIdle;
         wBeat <= '0;
      end else begin
         state <= stateNext;
         wBeat <= (state == StWBurst) ? wBeat + 3'd1 : 3'd0;
      end
   end

   // Dest queue and registered read-data return
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) destQ[i] <= '0;
         dqWrPtr  <= '0;
         dqRdPtr  <= '0;
         dqCount  <= '0;
         rBeat    <= '0;
         RDreturn <= '0;
         RDdest   <= '0;
      end else begin
         if (dqPush) begin
            destQ[dqWrPtr] <= cmdHead[31:28];
            dqWrPtr        <= dqWrPtr + 2'd1;
         end
         if (beatOk) begin
            RDreturn <= memRData;
            RDdest   <= destQ[dqRdPtr];
            rBeat    <= rBeat + 3'd1;
            if (dqPop) dqRdPtr <= dqRdPtr + 2'd1;
         end else begin
            RDreturn <= '0;
            RDdest   <= '0;
         end
         case ({dqPush, dqPop})
            2'b10:   dqCount <= dqCount + 3'd1;
            2'b01:   dqCount <= dqCount - 3'd1;
            default: dqCount <= dqCount;
         endcase
      end
   end

   // Sticky protocol error
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         protocolErr <= 1'b0;
      end else if (errSet || (memRValid && (dqCount == 3'd0))) begin
         protocolErr <= 1'b1;
      end
   end

endmodule
